// File: rtl/hack_exec_unit.sv
// hack_exec_unit: multi-cycle Hack instruction sequencer around an external ALU.
//   Fetches an instruction, decodes it, optionally reads data memory, commits
//   the ALU result in EXEC, then optionally writes data memory.
// Ports:
//   clk, reset               - clock; synchronous active-high reset
//   fetch_req/pc             - instruction fetch request and address
//   instruction/instr_valid  - instruction word and fetch acknowledge
//   mem_req/writeM/addressM  - data access request, direction, address
//   outM/inM/mem_ready       - write data, read data, access acknowledge
//   alu_x/alu_y/alu_zx..no   - operands and controls to the ALU
//   alu_out/alu_zr/alu_ng    - ALU result and flags
module hack_exec_unit #(
    parameter int PC_W   = 15,
    parameter int RST_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instruction,
    input  logic            instr_valid,
    output logic            mem_req,
    output logic            writeM,
    output logic [PC_W-1:0] addressM,
    output logic [15:0]     outM,
    input  logic [15:0]     inM,
    input  logic            mem_ready,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_EXEC,
        S_MEM_WR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     d_q, d_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     mdr_q, mdr_d;
    logic [15:0]     res_q, res_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] war_q, war_d;

    logic            jump;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + PC_W'(1);
    assign jump   = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        res_d   = res_q;
        pc_d    = pc_q;
        war_d   = war_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[15]) begin
                    a_d     = ir_q;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    state_d = ir_q[12] ? S_MEM_RD : S_EXEC;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    mdr_d   = inM;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d = alu_out;
                if (ir_q[4]) d_d = alu_out;
                if (ir_q[5]) a_d = alu_out;
                // jump target and write address come from A before this update
                pc_d = jump ? a_q[PC_W-1:0] : pc_inc;
                if (ir_q[3]) begin
                    war_d   = a_q[PC_W-1:0];
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            res_q   <= '0;
            pc_q    <= PC_W'(RST_PC);
            war_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            res_q   <= res_d;
            pc_q    <= pc_d;
            war_q   <= war_d;
        end
    end

    // Requests are gated by reset so an in-flight access drops in the reset cycle.
    assign fetch_req = ~reset & (state_q == S_FETCH);
    assign mem_req   = ~reset & ((state_q == S_MEM_RD) | (state_q == S_MEM_WR));
    assign writeM    = ~reset & (state_q == S_MEM_WR);
    assign addressM  = (state_q == S_MEM_WR) ? war_q : a_q[PC_W-1:0];
    assign outM      = res_q;
    assign pc        = pc_q;

    assign alu_x  = d_q;
    assign alu_y  = ir_q[12] ? mdr_q : a_q;
    assign alu_zx = ir_q[11];
    assign alu_nx = ir_q[10];
    assign alu_zy = ir_q[9];
    assign alu_ny = ir_q[8];
    assign alu_f  = ir_q[7];
    assign alu_no = ir_q[6];

endmodule

// File: tb/tb_hack_exec_unit.sv
// Randomized bench for hack_exec_unit: an instruction-level Hack model predicts
// A, D, PC, memory traffic and cycle counts for each instruction.
module tb_hack_exec_unit;
    localparam int PC_W = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_req;
    logic [PC_W-1:0] pc;
    logic [15:0]     instruction;
    logic            instr_valid;
    logic            mem_req, writeM;
    logic [PC_W-1:0] addressM;
    logic [15:0]     outM, inM;
    logic            mem_ready;
    logic [15:0]     alu_x, alu_y, alu_out;
    logic            alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0]     dmem [0:32767];
    logic [15:0]     mA, mD;
    logic [PC_W-1:0] mPC;

    always #5 clk = ~clk;

    hack_exec_unit #(.PC_W(PC_W), .RST_PC(0)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
        .instruction(instruction), .instr_valid(instr_valid),
        .mem_req(mem_req), .writeM(writeM), .addressM(addressM), .outM(outM),
        .inM(inM), .mem_ready(mem_ready),
        .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx),
        .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? xx + yy : xx & yy;
        return c[0] ? ~o : o;
    endfunction

    // Combinational ALU stub standing in for the top-level ALU instance.
    assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 16'h0);
    assign alu_ng  = alu_out[15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch();
        chk("pc", 32'(pc), 32'(mPC));
        chk("A", 32'(addressM), 32'(mA[PC_W-1:0]));
        chk("D", 32'(alu_x), 32'(mD));
        chk("fetch_req", 32'(fetch_req), 32'd1);
        chk("mem_req_idle", 32'(mem_req), 32'd0);
    endtask

    // Wait for FETCH, check architectural state, then run one instruction with
    // fw fetch waits and mw waits on every data access.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw);
        int          g, cyc, wc, exp_cyc;
        logic        rd_left, wr_left, jmp, acc;
        logic [15:0] oldA, mval, res;
        g = 0;
        while (!fetch_req && g < 40) begin step(); g++; end
        if (!fetch_req) begin
            chk("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        check_fetch();
        repeat (fw) step();
        instruction = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;

        oldA    = mA;
        rd_left = ins[15] & ins[12];
        wr_left = ins[15] & ins[3];
        res     = 16'h0;
        if (!ins[15]) begin
            mA      = ins;
            mPC     = mPC + 1'b1;
            exp_cyc = 1;
        end else begin
            mval = dmem[oldA[PC_W-1:0]];
            res  = hack_alu(mD, ins[12] ? mval : oldA, ins[11:6]);
            jmp  = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0) ||
                   (ins[0] && $signed(res) > 0);
            if (ins[5]) mA = res;
            if (ins[4]) mD = res;
            mPC     = jmp ? oldA[PC_W-1:0] : mPC + 1'b1;
            exp_cyc = 2 + (rd_left ? 1 + mw : 0) + (wr_left ? 1 + mw : 0);
        end

        cyc = 0;
        wc  = 0;
        while (!fetch_req && cyc < 40) begin
            acc         = 1'b0;
            // noise on acknowledges that must be ignored in this state
            instr_valid = 1'($urandom_range(0, 1));
            instruction = 16'($urandom);
            inM         = 16'($urandom);
            if (mem_req) begin
                chk("addressM", 32'(addressM), 32'(oldA[PC_W-1:0]));
                if (rd_left) begin
                    chk("writeM_rd", 32'(writeM), 32'd0);
                end else if (wr_left) begin
                    chk("writeM_wr", 32'(writeM), 32'd1);
                    chk("outM", 32'(outM), 32'(res));
                end else begin
                    chk("spurious_req", 32'(mem_req), 32'd0);
                end
                if (wc == mw) begin
                    mem_ready = 1'b1;
                    acc       = 1'b1;
                    if (rd_left) inM = dmem[oldA[PC_W-1:0]];
                end else begin
                    mem_ready = 1'b0;
                    wc++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            step();
            instr_valid = 1'b0;
            mem_ready   = 1'b0;
            if (acc) begin
                if (rd_left) rd_left = 1'b0;
                else if (wr_left) begin
                    wr_left = 1'b0;
                    dmem[oldA[PC_W-1:0]] = res;
                end
                wc = 0;
            end
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_cyc));
    endtask

    logic [15:0] dir_ins [0:16];
    int          dir_mw  [0:16];

    initial begin
        int g;
        reset = 1'b1; instr_valid = 1'b0; instruction = 16'h0;
        mem_ready = 1'b0; inM = 16'h0;
        for (int i = 0; i < 32768; i++) dmem[i] = 16'($urandom);
        dmem[200] = 16'h8001;
        dmem[7]   = 16'h0003;
        mA = 16'h0; mD = 16'h0; mPC = '0;

        step(); step();
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_writeM", 32'(writeM), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        reset = 1'b0;
        #1;

        dir_ins = '{16'h0005, 16'hEC10, 16'h0029, 16'hEC10, 16'h0064, 16'hE7C8,
                    16'h00C8, 16'hFC10, 16'h0000, 16'hEC10, 16'h0010, 16'hE302,
                    16'h0007, 16'hFDEF, 16'h7FFF, 16'hEA87, 16'h0001};
        dir_mw  = '{0, 0, 0, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 17; i++) run_instr(dir_ins[i], 0, dir_mw[i]);

        for (int i = 0; i < 250; i++) begin
            logic [15:0] ins;
            if ($urandom_range(0, 1) == 0) ins = {1'b0, 15'($urandom)};
            else                           ins = {3'b111, 13'($urandom)};
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while a write is stalled waiting for its acknowledge.
        run_instr(16'h0009, 0, 0);
        g = 0;
        while (!fetch_req && g < 40) begin step(); g++; end
        check_fetch();
        instruction = 16'hE308;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        g = 0;
        while (!(mem_req && writeM) && g < 10) begin step(); g++; end
        chk("wr_reached", 32'(mem_req & writeM), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_writeM", 32'(writeM), 32'd0);
        chk("rst_mid_fetch_req", 32'(fetch_req), 32'd0);
        step();
        reset = 1'b0;
        #1;
        mA = 16'h0; mD = 16'h0; mPC = '0;
        run_instr(16'h1234, 1, 0);
        run_instr(16'hEC10, 0, 0);
        g = 0;
        while (!fetch_req && g < 40) begin step(); g++; end
        check_fetch();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
